// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the 8-bit CPU control path.
//   - Field widths (opcode nibble, packed control word, T-state index).
//   - Opcode values OP_NOP..OP_HLT.
//   - Control-word bit indices CB_*; the datapath unpacks ctrl_word with these.
//   - Sequencer state encoding: T0..T6 map directly onto the T-state index,
//     CLR and HALT sit above them.
package cpu_ctrl_pkg;

    localparam int OPCODE_W = 4;
    localparam int CTRL_W   = 24;
    localparam int T_W      = 3;

    // Opcodes (upper nibble of the instruction register)
    localparam logic [OPCODE_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_LDA  = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_STA  = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_LDI  = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_JZ   = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_JC   = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_IN   = 4'h9;
    localparam logic [OPCODE_W-1:0] OP_OUT  = 4'hA;
    localparam logic [OPCODE_W-1:0] OP_MOVB = 4'hB;
    localparam logic [OPCODE_W-1:0] OP_MOVC = 4'hC;
    localparam logic [OPCODE_W-1:0] OP_HLT  = 4'hF;

    // Control-word bit indices
    localparam int CB_COUNT_PC       = 0;
    localparam int CB_CLEAR_PC       = 1;
    localparam int CB_ENABLE_PC      = 2;
    localparam int CB_LOAD_PC        = 3;
    localparam int CB_LOAD_ACCUM     = 4;
    localparam int CB_ENABLE_ACCUM   = 5;
    localparam int CB_LOAD_MAR       = 6;
    localparam int CB_CE_RAM         = 7;
    localparam int CB_WE_RAM         = 8;
    localparam int CB_SUB_MODE       = 9;
    localparam int CB_ENABLE_ALU     = 10;
    localparam int CB_LOAD_MDR_REG   = 11;
    localparam int CB_ENABLE_MDR_REG = 12;
    localparam int CB_LOAD_B_REG     = 13;
    localparam int CB_ENABLE_B_REG   = 14;
    localparam int CB_LOAD_C_REG     = 15;
    localparam int CB_ENABLE_C_REG   = 16;
    localparam int CB_LOAD_TEMP_REG  = 17;
    localparam int CB_LOAD_OUTPUT_REG = 18;
    localparam int CB_LOAD_INST_REG  = 19;
    localparam int CB_ENABLE_INST_REG = 20;
    localparam int CB_CLEAR_INST_REG = 21;
    localparam int CB_ENABLE_INPUT   = 22;
    localparam int CB_FLIP_FLOP      = 23;

    // Sequencer states. T0..T6 equal their T-state index.
    typedef enum logic [3:0] {
        T0   = 4'd0,
        T1   = 4'd1,
        T2   = 4'd2,
        T3   = 4'd3,
        T4   = 4'd4,
        T5   = 4'd5,
        T6   = 4'd6,
        CLR  = 4'd7,
        HALT = 4'd8
    } state_t;

    // One-hot control word with a single line asserted.
    function automatic logic [CTRL_W-1:0] cbit(input int idx);
        cbit = {{(CTRL_W-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Debug T-state index: CLR and HALT both report 7.
    function automatic logic [T_W-1:0] to_t_state(input state_t s);
        if (s == HALT || s == CLR) to_t_state = 3'd7;
        else                       to_t_state = s[T_W-1:0];
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control-path bundle between the sequencer and the datapath.
//   opcode, zero_flag, carry_flag : datapath -> sequencer
//   ctrl_word, t_state, halted    : sequencer -> datapath
// There is no valid/ready handshake: every signal is meaningful on every
// cycle, ctrl_word is combinational from the current state and the inputs.
// modport master = sequencer side, modport slave = datapath side.
interface control_sequencer_if;
    import cpu_ctrl_pkg::*;

    logic [OPCODE_W-1:0] opcode;
    logic                zero_flag;
    logic                carry_flag;
    logic [CTRL_W-1:0]   ctrl_word;
    logic [T_W-1:0]      t_state;
    logic                halted;

    modport master (
        input  opcode, zero_flag, carry_flag,
        output ctrl_word, t_state, halted
    );

    modport slave (
        output opcode, zero_flag, carry_flag,
        input  ctrl_word, t_state, halted
    );
endinterface

// File: rtl/control_decoder.sv
// Pure combinational microcode table.
//   Inputs : state, opcode, zero_flag, carry_flag
//   Outputs: ctrl_word (datapath control lines), next_state
// Flags only influence the T3 decision of JZ/JC; in every other state they
// are ignored. The last execute state of each instruction returns to T0.
module control_decoder
    import cpu_ctrl_pkg::*;
(
    input  state_t              state,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero_flag,
    input  logic                carry_flag,
    output logic [CTRL_W-1:0]   ctrl_word,
    output state_t              next_state
);

    always_comb begin
        ctrl_word  = '0;
        next_state = CLR;
        unique case (state)
            CLR: begin
                ctrl_word  = cbit(CB_CLEAR_PC) | cbit(CB_CLEAR_INST_REG);
                next_state = T0;
            end
            HALT: begin
                next_state = HALT;
            end
            // Fetch
            T0: begin
                ctrl_word  = cbit(CB_ENABLE_PC) | cbit(CB_LOAD_MAR);
                next_state = T1;
            end
            T1: begin
                ctrl_word  = cbit(CB_CE_RAM) | cbit(CB_LOAD_MDR_REG) | cbit(CB_COUNT_PC);
                next_state = T2;
            end
            T2: begin
                ctrl_word  = cbit(CB_ENABLE_MDR_REG) | cbit(CB_LOAD_INST_REG);
                next_state = T3;
            end
            // Execute
            T3: begin
                next_state = T0;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl_word  = cbit(CB_ENABLE_INST_REG) | cbit(CB_LOAD_MAR);
                        next_state = T4;
                    end
                    OP_LDI:  ctrl_word = cbit(CB_ENABLE_INST_REG) | cbit(CB_LOAD_ACCUM);
                    OP_JMP:  ctrl_word = cbit(CB_ENABLE_INST_REG) | cbit(CB_LOAD_PC);
                    OP_JZ:   if (zero_flag)
                                 ctrl_word = cbit(CB_ENABLE_INST_REG) | cbit(CB_LOAD_PC);
                    OP_JC:   if (carry_flag)
                                 ctrl_word = cbit(CB_ENABLE_INST_REG) | cbit(CB_LOAD_PC);
                    OP_IN:   ctrl_word = cbit(CB_ENABLE_INPUT) | cbit(CB_LOAD_ACCUM);
                    OP_OUT:  ctrl_word = cbit(CB_ENABLE_ACCUM) | cbit(CB_LOAD_OUTPUT_REG);
                    OP_MOVB: ctrl_word = cbit(CB_ENABLE_ACCUM) | cbit(CB_LOAD_B_REG);
                    OP_MOVC: ctrl_word = cbit(CB_ENABLE_ACCUM) | cbit(CB_LOAD_C_REG);
                    OP_HLT:  next_state = HALT;
                    default: ;  // NOP and undefined opcodes: empty T3
                endcase
            end
            T4: begin
                next_state = T5;
                if (opcode == OP_STA)
                    ctrl_word = cbit(CB_ENABLE_ACCUM) | cbit(CB_LOAD_MDR_REG);
                else
                    ctrl_word = cbit(CB_CE_RAM) | cbit(CB_LOAD_MDR_REG);
            end
            T5: begin
                next_state = T0;
                case (opcode)
                    OP_ADD, OP_SUB: begin
                        ctrl_word  = cbit(CB_ENABLE_MDR_REG) | cbit(CB_LOAD_TEMP_REG);
                        next_state = T6;
                    end
                    OP_STA:  ctrl_word = cbit(CB_CE_RAM) | cbit(CB_WE_RAM) | cbit(CB_FLIP_FLOP);
                    default: ctrl_word = cbit(CB_ENABLE_MDR_REG) | cbit(CB_LOAD_ACCUM);
                endcase
            end
            T6: begin
                next_state = T0;
                ctrl_word  = cbit(CB_ENABLE_ALU) | cbit(CB_LOAD_ACCUM);
                if (opcode == OP_SUB) ctrl_word = ctrl_word | cbit(CB_SUB_MODE);
            end
            default: begin
                next_state = CLR;  // unreachable encodings recover through CLR
            end
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// T-state sequencer for the 8-bit CPU.
//   clk     : rising-edge clock
//   clear_n : asynchronous active-low reset; forces CLR immediately
//   bus     : master side of control_sequencer_if
//             (opcode/flags in, ctrl_word/t_state/halted out)
// The state register lives here; control_decoder supplies both the
// control word for the current state and the state to enter next.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                clear_n,
    control_sequencer_if.master bus
);

    state_t            state;
    state_t            next_state;
    logic [CTRL_W-1:0] dec_ctrl;

    control_decoder u_decoder (
        .state      (state),
        .opcode     (bus.opcode),
        .zero_flag  (bus.zero_flag),
        .carry_flag (bus.carry_flag),
        .ctrl_word  (dec_ctrl),
        .next_state (next_state)
    );

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) state <= CLR;
        else          state <= next_state;
    end

    assign bus.ctrl_word = dec_ctrl;
    assign bus.t_state   = to_t_state(state);
    assign bus.halted    = (state == HALT);

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    // Control-line masks written from the published bit map
    localparam logic [23:0] M_COUNT_PC   = 24'h000001;
    localparam logic [23:0] M_CLEAR_PC   = 24'h000002;
    localparam logic [23:0] M_ENABLE_PC  = 24'h000004;
    localparam logic [23:0] M_LOAD_PC    = 24'h000008;
    localparam logic [23:0] M_LOAD_ACC   = 24'h000010;
    localparam logic [23:0] M_ENABLE_ACC = 24'h000020;
    localparam logic [23:0] M_LOAD_MAR   = 24'h000040;
    localparam logic [23:0] M_CE_RAM     = 24'h000080;
    localparam logic [23:0] M_WE_RAM     = 24'h000100;
    localparam logic [23:0] M_SUB_MODE   = 24'h000200;
    localparam logic [23:0] M_ENABLE_ALU = 24'h000400;
    localparam logic [23:0] M_LOAD_MDR   = 24'h000800;
    localparam logic [23:0] M_ENABLE_MDR = 24'h001000;
    localparam logic [23:0] M_LOAD_B     = 24'h002000;
    localparam logic [23:0] M_ENABLE_B   = 24'h004000;
    localparam logic [23:0] M_LOAD_C     = 24'h008000;
    localparam logic [23:0] M_ENABLE_C   = 24'h010000;
    localparam logic [23:0] M_LOAD_TEMP  = 24'h020000;
    localparam logic [23:0] M_LOAD_OUT   = 24'h040000;
    localparam logic [23:0] M_LOAD_INST  = 24'h080000;
    localparam logic [23:0] M_ENABLE_INST = 24'h100000;
    localparam logic [23:0] M_CLEAR_INST = 24'h200000;
    localparam logic [23:0] M_ENABLE_IN  = 24'h400000;
    localparam logic [23:0] M_FLIP_FLOP  = 24'h800000;
    localparam logic [23:0] BUS_DRIVERS  = M_ENABLE_PC | M_ENABLE_ACC | M_ENABLE_ALU |
                                           M_ENABLE_MDR | M_ENABLE_B | M_ENABLE_C |
                                           M_ENABLE_INST | M_ENABLE_IN;

    localparam int W = 28;  // {halted, t_state[2:0], ctrl_word[23:0]}
    localparam logic [W-1:0] E_CLR = {1'b0, 3'd7, 24'h200002};
    localparam logic [W-1:0] E_HALT = {1'b1, 3'd7, 24'h000000};

    // ---------------- clock / reset ----------------
    logic clk;
    logic clear_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    control_sequencer_if bus_if ();

    control_sequencer dut (
        .clk     (clk),
        .clear_n (clear_n),
        .bus     (bus_if)
    );

    // ---------------- model ----------------
    logic [W-1:0] exp_q[$];
    logic [23:0]  seq_w [0:6];
    int checks = 0;
    int errors = 0;

    // Builds the full control-word list of one instruction (fetch + execute)
    // into seq_w and returns its length.
    function automatic int build_seq(input logic [3:0] op, input logic z, input logic c);
        int n;
        seq_w[0] = M_ENABLE_PC | M_LOAD_MAR;
        seq_w[1] = M_CE_RAM | M_LOAD_MDR | M_COUNT_PC;
        seq_w[2] = M_ENABLE_MDR | M_LOAD_INST;
        for (int i = 3; i < 7; i++) seq_w[i] = 24'h0;
        n = 4;
        case (op)
            4'h1: begin
                seq_w[3] = M_ENABLE_INST | M_LOAD_MAR;
                seq_w[4] = M_CE_RAM | M_LOAD_MDR;
                seq_w[5] = M_ENABLE_MDR | M_LOAD_ACC;
                n = 6;
            end
            4'h2, 4'h3: begin
                seq_w[3] = M_ENABLE_INST | M_LOAD_MAR;
                seq_w[4] = M_CE_RAM | M_LOAD_MDR;
                seq_w[5] = M_ENABLE_MDR | M_LOAD_TEMP;
                seq_w[6] = M_ENABLE_ALU | M_LOAD_ACC | ((op == 4'h3) ? M_SUB_MODE : 24'h0);
                n = 7;
            end
            4'h4: begin
                seq_w[3] = M_ENABLE_INST | M_LOAD_MAR;
                seq_w[4] = M_ENABLE_ACC | M_LOAD_MDR;
                seq_w[5] = M_CE_RAM | M_WE_RAM | M_FLIP_FLOP;
                n = 6;
            end
            4'h5: seq_w[3] = M_ENABLE_INST | M_LOAD_ACC;
            4'h6: seq_w[3] = M_ENABLE_INST | M_LOAD_PC;
            4'h7: seq_w[3] = z ? (M_ENABLE_INST | M_LOAD_PC) : 24'h0;
            4'h8: seq_w[3] = c ? (M_ENABLE_INST | M_LOAD_PC) : 24'h0;
            4'h9: seq_w[3] = M_ENABLE_IN | M_LOAD_ACC;
            4'hA: seq_w[3] = M_ENABLE_ACC | M_LOAD_OUT;
            4'hB: seq_w[3] = M_ENABLE_ACC | M_LOAD_B;
            4'hC: seq_w[3] = M_ENABLE_ACC | M_LOAD_C;
            default: ;
        endcase
        return n;
    endfunction

    task automatic pin(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s model=%06h expected=%06h", name, act, exp);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] e;
        act = {bus_if.halted, bus_if.t_state, bus_if.ctrl_word};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL seq t=%0t halted/t_state/ctrl got=%0b/%0d/%06h want=%0b/%0d/%06h",
                         $time, act[27], act[26:24], act[23:0], e[27], e[26:24], e[23:0]);
            end
        end
        checks++;
        if ($countones(bus_if.ctrl_word & BUS_DRIVERS) > 1) begin
            errors++;
            $display("FAIL bus_invariant t=%0t ctrl=%06h allowed<=1 driver", $time, bus_if.ctrl_word);
        end
        checks++;
        if (bus_if.ctrl_word[8] && !bus_if.ctrl_word[7]) begin
            errors++;
            $display("FAIL we_implies_ce t=%0t ctrl=%06h", $time, bus_if.ctrl_word);
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end at posedge+1.
    task automatic do_reset(input int cycles);
        clear_n = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            exp_q.push_back(E_CLR);
            @(posedge clk); #1;
        end
        clear_n = 1'b1;
        exp_q.push_back(E_CLR);   // still CLR until the next edge
        @(posedge clk); #1;
    endtask

    // Runs one instruction from T0; flags carry the intended value only in
    // T3 and random noise everywhere else. Stops early (async reset) at
    // state abort_at when abort_at is in 1..n-1.
    task automatic run_instr(input logic [3:0] op, input logic z, input logic c,
                             input int abort_at);
        int n;
        n = build_seq(op, z, c);
        bus_if.opcode = op;
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                do_reset(2);
                return;
            end
            bus_if.zero_flag  = (i == 3) ? z : 1'($urandom_range(0, 1));
            bus_if.carry_flag = (i == 3) ? c : 1'($urandom_range(0, 1));
            exp_q.push_back({1'b0, 3'(i), seq_w[i]});
            @(posedge clk); #1;
        end
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bus_if.opcode     = 4'($urandom_range(0, 15));
            bus_if.zero_flag  = 1'($urandom_range(0, 1));
            bus_if.carry_flag = 1'($urandom_range(0, 1));
            exp_q.push_back(E_HALT);
            @(posedge clk); #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        clear_n           = 1'b0;
        bus_if.opcode     = 4'h0;
        bus_if.zero_flag  = 1'b0;
        bus_if.carry_flag = 1'b0;

        // Pin the model against hand-computed words
        n = build_seq(4'h1, 1'b0, 1'b0);
        pin("lda_t0", seq_w[0], 24'h000044);
        pin("lda_t3", seq_w[3], 24'h100040);
        pin("lda_t4", seq_w[4], 24'h000880);
        pin("lda_t5", seq_w[5], 24'h001010);
        n = build_seq(4'h3, 1'b0, 1'b0);
        pin("sub_t6", seq_w[6], 24'h000610);
        n = build_seq(4'h4, 1'b0, 1'b0);
        pin("sta_t4", seq_w[4], 24'h000820);
        pin("sta_t5", seq_w[5], 24'h800180);
        n = build_seq(4'h7, 1'b1, 1'b0);
        pin("jz_taken", seq_w[3], 24'h100008);

        @(posedge clk); #1;
        do_reset(3);

        // Directed: every opcode, both flag outcomes for JZ/JC
        run_instr(4'h1, 1'b0, 1'b0, -1);
        run_instr(4'h2, 1'b0, 1'b0, -1);
        run_instr(4'h3, 1'b1, 1'b1, -1);
        run_instr(4'h4, 1'b0, 1'b0, -1);
        run_instr(4'h0, 1'b1, 1'b1, -1);
        run_instr(4'h5, 1'b0, 1'b0, -1);
        run_instr(4'h6, 1'b0, 1'b0, -1);
        run_instr(4'h7, 1'b1, 1'b0, -1);
        run_instr(4'h7, 1'b0, 1'b1, -1);
        run_instr(4'h8, 1'b0, 1'b1, -1);
        run_instr(4'h8, 1'b1, 1'b0, -1);
        run_instr(4'h9, 1'b0, 1'b0, -1);
        run_instr(4'hA, 1'b0, 1'b0, -1);
        run_instr(4'hB, 1'b0, 1'b0, -1);
        run_instr(4'hC, 1'b0, 1'b0, -1);
        run_instr(4'hD, 1'b1, 1'b1, -1);
        run_instr(4'hE, 1'b0, 1'b0, -1);

        // Mid-instruction abort of an ADD in T5
        run_instr(4'h2, 1'b0, 1'b0, 5);
        run_instr(4'h1, 1'b0, 1'b0, -1);

        // Halt, stay halted, leave through reset
        run_instr(4'hF, 1'b0, 1'b0, -1);
        halt_cycles(22);
        do_reset(1);
        run_instr(4'h4, 1'b0, 1'b0, -1);

        // Random sweep with one async abort in the middle
        for (int k = 0; k < 40; k++) begin
            logic [3:0] op;
            logic z, c;
            op = 4'($urandom_range(0, 14));
            z  = 1'($urandom_range(0, 1));
            c  = 1'($urandom_range(0, 1));
            if (k == 20) begin
                n = build_seq(op, z, c);
                run_instr(op, z, c, $urandom_range(1, n - 1));
            end else begin
                run_instr(op, z, c, -1);
            end
        end
        run_instr(4'hF, 1'b0, 1'b0, -1);
        halt_cycles(3);

        @(posedge clk); #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain left=%0d want=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded-style FSM that drives the datapath control lines. Fetch, decode and execute of the 8-bit CPU are sequenced as T-states.
- Consumes the instruction register opcode nibble and the ALU zero and carry flags. Produces the packed control word that the top level fans out to the datapath.
- Instructions are variable length: 4-7 states each.

Parameters:
- OPCODE_W, 4, width of opcode field from the instruction register.
- CTRL_W, 24, width of packed control word.
- T_W, 3, width of T-state index output.

Ports:
- clk  in  1  system clock, rising edge.
- clear_n  in  1  asynchronous, active-low reset.
- opcode  in  OPCODE_W  upper nibble of the instruction register. Valid from T3 onward.
- zero_flag  in  1  ALU zero flag, sampled combinationally in T3.
- carry_flag  in  1  ALU carry flag, sampled combinationally in T3.
- ctrl_word  out  CTRL_W  datapath control lines, one-hot per line (bit map below).
- t_state  out  T_W  current T-state: 0-6, 7 = CLR/HALT (debug).
- halted  out  1  high while in HALT.

Behaviour:
- Control word bit map:
  - bits 0-7: count_pc, clear_pc, enable_pc, load_pc, load_accum, enable_accum, load_mar, ce_ram.
  - bits 8-15: we_ram, sub_mode, enable_alu, load_mdr_reg, enable_mdr_reg, load_b_reg, enable_b_reg, load_c_reg.
  - bits 16-23: enable_c_reg, load_temp_reg, load_output_reg, load_inst_reg, enable_inst_reg, clear_inst_reg, enable_input, flip_flop.
- Decode timing: ctrl_word is combinational from {state, opcode, flags}, with zero-cycle latency. The state register updates on the rising edge of clk.
- Reset:
  - While clear_n = 0, state = CLR and ctrl_word = clear_pc | clear_inst_reg. All other bits 0; halted = 0; t_state = 7.
  - The first edge after release goes CLR -> T0.
  - Reset mid-instruction aborts it immediately (asynchronous) and returns to CLR.
- Fetch, identical for all instructions:
  - T0: enable_pc, load_mar.
  - T1: ce_ram, load_mdr_reg, count_pc.
  - T2: enable_mdr_reg, load_inst_reg.
- Execute by opcode. The last listed state returns to T0 on the next edge.
  - 0 NOP: T3 with no control lines asserted.
  - 1 LDA a: T3 enable_inst_reg, load_mar; T4 ce_ram, load_mdr_reg; T5 enable_mdr_reg, load_accum.
  - 2 ADD a: as LDA through T4; T5 enable_mdr_reg, load_temp_reg; T6 enable_alu, load_accum.
  - 3 SUB a: as ADD, with sub_mode also asserted in T6.
  - 4 STA a: T3 enable_inst_reg, load_mar; T4 enable_accum, load_mdr_reg; T5 ce_ram, we_ram, flip_flop.
  - 5 LDI n: T3 enable_inst_reg, load_accum.
  - 6 JMP a: T3 enable_inst_reg, load_pc.
  - 7 JZ a: as JMP if zero_flag = 1, else T3 empty.
  - 8 JC a: as JMP if carry_flag = 1, else T3 empty.
  - 9 IN: T3 enable_input, load_accum.
  - A OUT: T3 enable_accum, load_output_reg.
  - B MOVB: T3 enable_accum, load_b_reg.
  - C MOVC: T3 enable_accum, load_c_reg.
  - D, E (undefined): execute as NOP.
  - F HLT: T3 -> HALT.
- HALT: ctrl_word = 0, halted = 1. HALT is left only by reset.
- Bus invariant: at most one of enable_pc, enable_accum, enable_alu, enable_mdr_reg, enable_b_reg, enable_c_reg, enable_inst_reg, enable_input is high in any cycle.
- Write invariant: we_ram implies ce_ram.
- Flags are sampled only in T3. Changes in other states are ignored.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - opcode localparams OP_NOP..OP_HLT.
  - control-bit index localparams CB_COUNT_PC..CB_FLIP_FLOP, plus CTRL_W.
  - state encoding T0..T6, CLR, HALT.
- The datapath top level uses the same bit indices to unpack ctrl_word.
- One sub-module, control_decoder: a pure combinational map from {state, opcode, zero_flag, carry_flag} to {ctrl_word, next_state}. The state register and reset logic stay in control_sequencer.

Test Plan:
- Reset: hold clear_n low for 3 cycles -> ctrl_word = 0x200002, t_state = 7. After release, the next edge gives t_state = 0 and ctrl_word = 0x000044.
- LDA then ADD: opcode 1 gives the T3-T5 sequence 0x100040, 0x000880, 0x001010, then back to T0. Opcode 2 ends with T6 = 0x000410. Opcode 3 ends with T6 = 0x000610.
- JZ: zero_flag = 1 -> T3 = 0x100008. zero_flag = 0 -> T3 = 0x000000. Both return to T0 next cycle. JC is checked the same way with carry_flag.
- STA: T3-T5 = 0x100040, 0x000820, 0x800180. we_ram is never high without ce_ram.
- HLT: opcode F -> halted = 1 and ctrl_word = 0 for 20+ cycles. Pulsing clear_n low returns to CLR, then T0.
- Random sweep: random opcodes and flags with a mid-instruction async reset -> bus invariant holds every cycle and each state sequence matches the table.
